lint_jtag_txn_guard: RTL and testbench
======================================

Name: lint_jtag_txn_guard

Overview:
- Sits directly downstream of the JTAG debug LINT master and upstream of the SoC crossbar port that master drives.
- Registers each debug request and forwards it as a single outstanding LINT transaction.
- Enforces grant and response timeouts so a hung slave cannot lock up the JTAG debug path.
- On timeout, returns a synthetic error response and records the event in sticky status.

Parameters:
- ADDR_WIDTH, 32, LINT address width
- DATA_WIDTH, 32, LINT data width; byte enable width is DATA_WIDTH/8
- TIMEOUT, 256, cycles to wait for grant and, separately, for response; 0 disables both timeouts
- ERR_DATA, 32'hBADACCE5, read data returned on a timeout error

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- s_req_i  in  1  request from JTAG LINT master
- s_add_i  in  ADDR_WIDTH  address
- s_wen_i  in  1  1 = read, 0 = write (LINT convention)
- s_wdata_i  in  DATA_WIDTH  write data
- s_be_i  in  DATA_WIDTH/8  byte enables
- s_gnt_o  out  1  grant to master
- s_r_valid_o  out  1  response valid pulse
- s_r_rdata_o  out  DATA_WIDTH  response data
- s_r_opc_o  out  1  response error flag
- m_req_o, m_add_o, m_wen_o, m_wdata_o, m_be_o  out  1/ADDR_WIDTH/1/DATA_WIDTH/DATA_WIDTH/8  request to crossbar
- m_gnt_i  in  1  crossbar grant
- m_r_valid_i  in  1  crossbar response valid
- m_r_rdata_i  in  DATA_WIDTH  crossbar response data
- m_r_opc_i  in  1  crossbar response error
- clr_i  in  1  clears timeout_o and err_count_o
- timeout_o  out  1  sticky flag: a timeout has occurred
- err_count_o  out  8  saturating count of timeouts plus dropped stale responses

Behaviour:
- Reset: state IDLE. All outputs 0, holding registers 0, counter 0.
- State IDLE:
  - s_gnt_o = s_req_i (combinational).
  - On s_req_i: capture add/wen/wdata/be, clear counter, go to REQ.
- State REQ:
  - m_req_o = 1; m_* driven from the holding registers and held stable until grant.
  - Counter increments each cycle.
  - m_gnt_i: go to RESP, counter cleared.
  - No grant and counter == TIMEOUT-1 (TIMEOUT != 0): go to ERR. m_req_o deasserts on the next cycle; the abandoned request is intentional.
- State RESP:
  - m_req_o = 0; counter increments each cycle.
  - m_r_valid_i: register m_r_rdata_i and m_r_opc_i to s_r_rdata_o/s_r_opc_o, assert s_r_valid_o for exactly 1 cycle, go to IDLE.
  - Counter == TIMEOUT-1 with no m_r_valid_i: go to ERR; set the internal stale_q flag.
- State ERR (1 cycle):
  - Next cycle: s_r_valid_o = 1, s_r_rdata_o = ERR_DATA, s_r_opc_o = 1.
  - timeout_o set; err_count_o incremented.
  - Go to IDLE.
- Latency, zero-wait slave:
  - Accept in cycle 0.
  - m_req_o in cycle 1.
  - m_gnt_i in cycle 1, m_r_valid_i in cycle 2.
  - s_r_valid_o in cycle 3.
- s_r_rdata_o and s_r_opc_o hold their value between pulses. s_r_valid_o is never high for 2 consecutive cycles from the same transaction.
- Only one transaction is outstanding at a time. s_gnt_o is 0 in REQ, RESP and ERR.
- A new accept may occur in the same cycle s_r_valid_o is high, since state is already IDLE.
- Stale responses: m_r_valid_i outside RESP is dropped and never forwarded.
  - err_count_o increments; stale_q clears.
  - If a stale response lands in RESP while stale_q = 1, it is also dropped and stale_q clears. The state stays in RESP waiting for the real response.
- err_count_o saturates at 255.
- clr_i clears timeout_o and err_count_o. If clr_i and an increment coincide, the result is 1 (timeout_o = 1, err_count_o = 1).
- Reset asserted mid-transaction: immediate return to IDLE; all outputs 0; stale_q cleared.

Test Plan:
- Read 0x1A10_0000, m_gnt_i high at cycle 1, m_r_valid_i at cycle 2 with 0xDEADBEEF -> m_req_o high cycle 1 only; s_r_valid_o cycle 3, rdata 0xDEADBEEF, opc 0.
- Write 0x1C00_0010, data 0x12345678, be 0xF, grant delayed 5 cycles -> m_req_o high 6 cycles with m_* stable; one s_r_valid_o pulse after m_r_valid_i.
- TIMEOUT=16, m_gnt_i never asserted -> m_req_o high 16 cycles then low; s_r_valid_o with 0xBADACCE5, opc 1; timeout_o=1, err_count_o=1.
- TIMEOUT=16, grant given, no response; after ERR, m_r_valid_i pulsed in IDLE -> no s_r_valid_o; err_count_o=2, stale_q cleared.
- rst_ni low during RESP -> all outputs 0 asynchronously; after release, a new read completes normally in 4 cycles.
- Force 300 timeouts -> err_count_o=255. Then clr_i together with a timeout -> err_count_o=1, timeout_o=1.

Source files
------------

// File: rtl/lint_jtag_txn_guard.sv
// lint_jtag_txn_guard
//
// Guards the LINT path between the JTAG debug master and its SoC crossbar
// port. Each debug request is registered and forwarded as the single
// outstanding crossbar transaction. A slave that never grants, or grants and
// never responds, is abandoned after TIMEOUT cycles. The master then gets a
// synthetic error response, so the debug path always completes.
//
// Ports
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   s_*                   slave side, driven by the JTAG LINT master
//   m_*                   master side, drives the crossbar port
//   clr_i                 clears timeout_o and err_count_o
//   timeout_o             sticky: at least one timeout since the last clear
//   err_count_o           saturating count of timeouts plus dropped stale
//                         responses
module lint_jtag_txn_guard #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 256,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA = 32'hBADACCE5
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    // debug master side
    input  logic                    s_req_i,
    input  logic [ADDR_WIDTH-1:0]   s_add_i,
    input  logic                    s_wen_i,
    input  logic [DATA_WIDTH-1:0]   s_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] s_be_i,
    output logic                    s_gnt_o,
    output logic                    s_r_valid_o,
    output logic [DATA_WIDTH-1:0]   s_r_rdata_o,
    output logic                    s_r_opc_o,
    // crossbar side
    output logic                    m_req_o,
    output logic [ADDR_WIDTH-1:0]   m_add_o,
    output logic                    m_wen_o,
    output logic [DATA_WIDTH-1:0]   m_wdata_o,
    output logic [DATA_WIDTH/8-1:0] m_be_o,
    input  logic                    m_gnt_i,
    input  logic                    m_r_valid_i,
    input  logic [DATA_WIDTH-1:0]   m_r_rdata_i,
    input  logic                    m_r_opc_i,
    // status
    input  logic                    clr_i,
    output logic                    timeout_o,
    output logic [7:0]              err_count_o
);

    localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8;
    localparam int unsigned CW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit          TIMEOUT_EN = (TIMEOUT != 0);
    // The last counter value before giving up. It is only used when TIMEOUT_EN is set.
    localparam logic [CW-1:0] CNT_MAX  = TIMEOUT_EN ? CW'(TIMEOUT - 1) : '0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] add_q, add_d;
    logic                  wen_q, wen_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BE_WIDTH-1:0]   be_q, be_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ropc_q, ropc_d;
    logic                  stale_q, stale_d;
    logic                  timeout_q, timeout_d;
    logic [7:0]            err_cnt_q, err_cnt_d;

    logic                  err_ev;
    logic                  stale_ev;
    logic [1:0]            inc;
    logic [8:0]            cnt_sum;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        add_d    = add_q;
        wen_d    = wen_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        ropc_d   = ropc_q;
        stale_d  = stale_q;
        err_ev   = 1'b0;
        stale_ev = 1'b0;

        // Drop a response that cannot belong to the current transaction.
        // This covers any response outside RESP. It also covers the first
        // response in RESP after a response timeout, because that response
        // is the late reply to the abandoned transaction.
        if (m_r_valid_i && ((state_q != ST_RESP) || stale_q)) begin
            stale_ev = 1'b1;
            stale_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (s_req_i) begin
                    add_d   = s_add_i;
                    wen_d   = s_wen_i;
                    wdata_d = s_wdata_i;
                    be_d    = s_be_i;
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (m_gnt_i) begin
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else if (TIMEOUT_EN && (cnt_q == CNT_MAX)) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (m_r_valid_i && !stale_q) begin
                    rvalid_d = 1'b1;
                    rdata_d  = m_r_rdata_i;
                    ropc_d   = m_r_opc_i;
                    state_d  = ST_IDLE;
                end else if (TIMEOUT_EN && (cnt_q == CNT_MAX)) begin
                    // The slave may still answer later. Remember this so that
                    // the late reply is not forwarded as a real response.
                    stale_d = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin // ST_ERR
                rvalid_d = 1'b1;
                rdata_d  = ERR_DATA;
                ropc_d   = 1'b1;
                err_ev   = 1'b1;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // A timeout and a dropped response can happen in the same cycle, so the
    // error counter can step by 2. Clear wins over the old value but not
    // over a new event, so a clear in the same cycle as an event leaves 1.
    always_comb begin
        inc       = {1'b0, err_ev} + {1'b0, stale_ev};
        cnt_sum   = {1'b0, err_cnt_q} + {7'b0, inc};
        timeout_d = clr_i ? err_ev : (timeout_q | err_ev);
        if (clr_i) begin
            err_cnt_d = {6'b0, inc};
        end else if (cnt_sum[8]) begin
            err_cnt_d = 8'hFF;
        end else begin
            err_cnt_d = cnt_sum[7:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            add_q     <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            be_q      <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            ropc_q    <= 1'b0;
            stale_q   <= 1'b0;
            timeout_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            add_q     <= add_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            ropc_q    <= ropc_d;
            stale_q   <= stale_d;
            timeout_q <= timeout_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // The master is granted only while the guard is idle. A request is
    // therefore never accepted while another transaction is outstanding.
    assign s_gnt_o     = (state_q == ST_IDLE) & s_req_i;
    assign s_r_valid_o = rvalid_q;
    assign s_r_rdata_o = rdata_q;
    assign s_r_opc_o   = ropc_q;

    assign m_req_o     = (state_q == ST_REQ);
    assign m_add_o     = add_q;
    assign m_wen_o     = wen_q;
    assign m_wdata_o   = wdata_q;
    assign m_be_o      = be_q;

    assign timeout_o   = timeout_q;
    assign err_count_o = err_cnt_q;

endmodule

// File: tb/tb_lint_jtag_txn_guard.sv
// Directed bench for lint_jtag_txn_guard with TIMEOUT = 16.
module tb_lint_jtag_txn_guard;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_req = 1'b0;
    logic [31:0] s_add = '0;
    logic        s_wen = 1'b0;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_be = '0;
    logic        s_gnt_o;
    logic        s_r_valid_o;
    logic [31:0] s_r_rdata_o;
    logic        s_r_opc_o;
    logic        m_req_o;
    logic [31:0] m_add_o;
    logic        m_wen_o;
    logic [31:0] m_wdata_o;
    logic [3:0]  m_be_o;
    logic        m_gnt = 1'b0;
    logic        m_r_valid = 1'b0;
    logic [31:0] m_r_rdata = '0;
    logic        m_r_opc = 1'b0;
    logic        clr = 1'b0;
    logic        timeout_o;
    logic [7:0]  err_count_o;

    int n_checks = 0;
    int n_fail   = 0;

    lint_jtag_txn_guard #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT   (16),
        .ERR_DATA  (32'hBADACCE5)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .s_req_i    (s_req),
        .s_add_i    (s_add),
        .s_wen_i    (s_wen),
        .s_wdata_i  (s_wdata),
        .s_be_i     (s_be),
        .s_gnt_o    (s_gnt_o),
        .s_r_valid_o(s_r_valid_o),
        .s_r_rdata_o(s_r_rdata_o),
        .s_r_opc_o  (s_r_opc_o),
        .m_req_o    (m_req_o),
        .m_add_o    (m_add_o),
        .m_wen_o    (m_wen_o),
        .m_wdata_o  (m_wdata_o),
        .m_be_o     (m_be_o),
        .m_gnt_i    (m_gnt),
        .m_r_valid_i(m_r_valid),
        .m_r_rdata_i(m_r_rdata),
        .m_r_opc_i  (m_r_opc),
        .clr_i      (clr),
        .timeout_o  (timeout_o),
        .err_count_o(err_count_o)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge.
    // Outputs are sampled 1 more time unit later.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        n_checks++;
        if ({m_req_o, s_r_valid_o, s_r_opc_o, timeout_o, s_gnt_o} !== 5'b0 ||
            s_r_rdata_o !== 32'h0 || err_count_o !== 8'h0 || m_add_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: m_req=%b rvalid=%b rdata=%h timeout=%b errcnt=%0d, required all 0",
                     m_req_o, s_r_valid_o, s_r_rdata_o, timeout_o, err_count_o);
        end
        #3 rst_n = 1'b1;
        tick();
        $display("txn reset released");
    endtask

    task automatic test_read_zero_wait;
        s_req = 1'b1; s_add = 32'h1A10_0000; s_wen = 1'b1; s_be = 4'hF; s_wdata = '0;
        #1;
        n_checks++;
        if (s_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL rd_gnt: got %b, required 1", s_gnt_o);
        end
        tick();
        s_req = 1'b0; m_gnt = 1'b1;
        #1;
        n_checks++;
        if ({m_req_o, m_wen_o, m_add_o, s_gnt_o} !== {1'b1, 1'b1, 32'h1A10_0000, 1'b0}) begin
            n_fail++;
            $display("FAIL rd_mreq: req=%b wen=%b add=%h gnt=%b, required 1 1 1a100000 0",
                     m_req_o, m_wen_o, m_add_o, s_gnt_o);
        end
        tick();
        m_gnt = 1'b0; m_r_valid = 1'b1; m_r_rdata = 32'hDEADBEEF; m_r_opc = 1'b0;
        #1;
        n_checks++;
        if ({m_req_o, s_r_valid_o} !== 2'b00) begin
            n_fail++; $display("FAIL rd_cycle2: m_req=%b rvalid=%b, required 0 0", m_req_o, s_r_valid_o);
        end
        tick();
        m_r_valid = 1'b0; m_r_rdata = '0;
        #1;
        n_checks++;
        if ({s_r_valid_o, s_r_opc_o, s_r_rdata_o} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL rd_resp: valid=%b opc=%b rdata=%h, required 1 0 deadbeef",
                     s_r_valid_o, s_r_opc_o, s_r_rdata_o);
        end
        tick();
        #1;
        n_checks++;
        if ({s_r_valid_o, s_r_rdata_o} !== {1'b0, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL rd_hold: valid=%b rdata=%h, required 0 deadbeef", s_r_valid_o, s_r_rdata_o);
        end
        $display("txn read 1a100000 -> %h", s_r_rdata_o);
    endtask

    task automatic test_write_delayed_grant;
        int pulses;
        s_req = 1'b1; s_add = 32'h1C00_0010; s_wen = 1'b0; s_wdata = 32'h1234_5678; s_be = 4'hF;
        tick();
        s_req = 1'b0; s_add = '0; s_wdata = '0; s_be = '0;
        for (int i = 0; i < 6; i++) begin
            m_gnt = (i == 5);
            #1;
            n_checks++;
            if ({m_req_o, m_wen_o, m_add_o, m_wdata_o, m_be_o} !==
                {1'b1, 1'b0, 32'h1C00_0010, 32'h1234_5678, 4'hF}) begin
                n_fail++;
                $display("FAIL wr_hold cycle %0d: req=%b wen=%b add=%h wdata=%h be=%h, required 1 0 1c000010 12345678 f",
                         i, m_req_o, m_wen_o, m_add_o, m_wdata_o, m_be_o);
            end
            tick();
        end
        m_gnt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if ({m_req_o, s_r_valid_o} !== 2'b00) begin
                n_fail++; $display("FAIL wr_wait: m_req=%b rvalid=%b, required 0 0", m_req_o, s_r_valid_o);
            end
            tick();
        end
        m_r_valid = 1'b1; m_r_rdata = 32'h0000_0000; m_r_opc = 1'b0;
        tick();
        m_r_valid = 1'b0;
        #1;
        n_checks++;
        if ({s_r_valid_o, s_r_opc_o} !== 2'b10) begin
            n_fail++; $display("FAIL wr_resp: valid=%b opc=%b, required 1 0", s_r_valid_o, s_r_opc_o);
        end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (s_r_valid_o === 1'b1) pulses++;
            tick();
            #1;
        end
        n_checks++;
        if (pulses !== 1) begin
            n_fail++; $display("FAIL wr_pulse_count: got %0d, required 1", pulses);
        end
        $display("txn write 1c000010 <- 12345678 done");
    endtask

    task automatic test_grant_timeout;
        s_req = 1'b1; s_add = 32'h1000_0000; s_wen = 1'b1;
        tick();
        s_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            n_checks++;
            if (m_req_o !== 1'b1) begin
                n_fail++; $display("FAIL gto_req cycle %0d: got %b, required 1", i, m_req_o);
            end
            tick();
        end
        #1;
        n_checks++;
        if ({m_req_o, s_r_valid_o, s_gnt_o} !== 3'b000) begin
            n_fail++; $display("FAIL gto_err_state: m_req=%b rvalid=%b gnt=%b, required 0 0 0",
                               m_req_o, s_r_valid_o, s_gnt_o);
        end
        tick();
        #1;
        n_checks++;
        if ({s_r_valid_o, s_r_opc_o, s_r_rdata_o} !== {1'b1, 1'b1, 32'hBADACCE5}) begin
            n_fail++;
            $display("FAIL gto_resp: valid=%b opc=%b rdata=%h, required 1 1 badacce5",
                     s_r_valid_o, s_r_opc_o, s_r_rdata_o);
        end
        n_checks++;
        if ({timeout_o, err_count_o} !== {1'b1, 8'd1}) begin
            n_fail++; $display("FAIL gto_status: timeout=%b errcnt=%0d, required 1 1", timeout_o, err_count_o);
        end
        tick();
        #1;
        n_checks++;
        if (s_r_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL gto_single_pulse: got %b, required 0", s_r_valid_o);
        end
        $display("txn grant timeout -> %h opc %b", s_r_rdata_o, s_r_opc_o);
    endtask

    // Starts a read, grants it, and never responds. This ends on the cycle
    // after ERR, when the error pulse is visible.
    task automatic run_resp_timeout;
        s_req = 1'b1; s_add = 32'h2000_0000; s_wen = 1'b1;
        tick();
        s_req = 1'b0; m_gnt = 1'b1;
        tick();
        m_gnt = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            n_checks++;
            if ({m_req_o, s_r_valid_o} !== 2'b00) begin
                n_fail++; $display("FAIL rto_wait cycle %0d: m_req=%b rvalid=%b, required 0 0",
                                   i, m_req_o, s_r_valid_o);
            end
            tick();
        end
        tick();
    endtask

    task automatic test_resp_timeout_stale;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        #1;
        n_checks++;
        if ({timeout_o, err_count_o} !== {1'b0, 8'd0}) begin
            n_fail++; $display("FAIL clr: timeout=%b errcnt=%0d, required 0 0", timeout_o, err_count_o);
        end
        run_resp_timeout();
        #1;
        n_checks++;
        if ({s_r_valid_o, s_r_opc_o, s_r_rdata_o, err_count_o} !== {1'b1, 1'b1, 32'hBADACCE5, 8'd1}) begin
            n_fail++;
            $display("FAIL rto_resp: valid=%b opc=%b rdata=%h errcnt=%0d, required 1 1 badacce5 1",
                     s_r_valid_o, s_r_opc_o, s_r_rdata_o, err_count_o);
        end
        m_r_valid = 1'b1; m_r_rdata = 32'h0000_0055; m_r_opc = 1'b0;
        tick();
        m_r_valid = 1'b0;
        #1;
        n_checks++;
        if ({s_r_valid_o, s_r_rdata_o, err_count_o} !== {1'b0, 32'hBADACCE5, 8'd2}) begin
            n_fail++;
            $display("FAIL stale_idle: valid=%b rdata=%h errcnt=%0d, required 0 badacce5 2",
                     s_r_valid_o, s_r_rdata_o, err_count_o);
        end
        // After stale_q has cleared, the next real response must be forwarded.
        s_req = 1'b1; s_add = 32'h2000_0004;
        tick();
        s_req = 1'b0; m_gnt = 1'b1;
        tick();
        m_gnt = 1'b0; m_r_valid = 1'b1; m_r_rdata = 32'hCAFE_F00D;
        tick();
        m_r_valid = 1'b0;
        #1;
        n_checks++;
        if ({s_r_valid_o, s_r_opc_o, s_r_rdata_o, err_count_o} !== {1'b1, 1'b0, 32'hCAFEF00D, 8'd2}) begin
            n_fail++;
            $display("FAIL post_stale_read: valid=%b opc=%b rdata=%h errcnt=%0d, required 1 0 cafef00d 2",
                     s_r_valid_o, s_r_opc_o, s_r_rdata_o, err_count_o);
        end
        tick();
        $display("txn response timeout, stale dropped, errcnt %0d", err_count_o);
    endtask

    task automatic test_stale_in_resp;
        run_resp_timeout();
        tick();
        s_req = 1'b1; s_add = 32'h2000_0008;
        tick();
        s_req = 1'b0; m_gnt = 1'b1;
        tick();
        // The first response in RESP is the late reply to the abandoned
        // transaction, so the guard must drop it.
        m_gnt = 1'b0; m_r_valid = 1'b1; m_r_rdata = 32'h1111_1111;
        tick();
        m_r_valid = 1'b0;
        #1;
        n_checks++;
        if ({s_r_valid_o, err_count_o} !== {1'b0, 8'd4}) begin
            n_fail++; $display("FAIL stale_resp_drop: valid=%b errcnt=%0d, required 0 4", s_r_valid_o, err_count_o);
        end
        m_r_valid = 1'b1; m_r_rdata = 32'h2222_2222;
        tick();
        m_r_valid = 1'b0;
        #1;
        n_checks++;
        if ({s_r_valid_o, s_r_rdata_o, err_count_o} !== {1'b1, 32'h2222_2222, 8'd4}) begin
            n_fail++;
            $display("FAIL stale_resp_real: valid=%b rdata=%h errcnt=%0d, required 1 22222222 4",
                     s_r_valid_o, s_r_rdata_o, err_count_o);
        end
        tick();
        $display("txn stale in RESP dropped, real -> %h", s_r_rdata_o);
    endtask

    task automatic test_back_to_back;
        s_req = 1'b1; s_add = 32'h3000_0000; s_wen = 1'b1;
        tick();
        s_req = 1'b0; m_gnt = 1'b1;
        tick();
        m_gnt = 1'b0; m_r_valid = 1'b1; m_r_rdata = 32'hA5A5_0001;
        tick();
        m_r_valid = 1'b0;
        s_req = 1'b1; s_add = 32'h3000_0004;
        #1;
        n_checks++;
        if ({s_r_valid_o, s_gnt_o} !== 2'b11) begin
            n_fail++; $display("FAIL b2b_accept: rvalid=%b gnt=%b, required 1 1", s_r_valid_o, s_gnt_o);
        end
        tick();
        s_req = 1'b0; m_gnt = 1'b1;
        #1;
        n_checks++;
        if ({m_req_o, m_add_o, s_r_valid_o} !== {1'b1, 32'h3000_0004, 1'b0}) begin
            n_fail++; $display("FAIL b2b_req: m_req=%b add=%h rvalid=%b, required 1 30000004 0",
                               m_req_o, m_add_o, s_r_valid_o);
        end
        tick();
        m_gnt = 1'b0; m_r_valid = 1'b1; m_r_rdata = 32'hA5A5_0002;
        tick();
        m_r_valid = 1'b0;
        #1;
        n_checks++;
        if ({s_r_valid_o, s_r_rdata_o} !== {1'b1, 32'hA5A5_0002}) begin
            n_fail++; $display("FAIL b2b_resp: valid=%b rdata=%h, required 1 a5a50002", s_r_valid_o, s_r_rdata_o);
        end
        tick();
        $display("txn back-to-back reads done");
    endtask

    task automatic test_async_reset;
        s_req = 1'b1; s_add = 32'h4000_0000; s_wen = 1'b1;
        tick();
        s_req = 1'b0; m_gnt = 1'b1;
        tick();
        m_gnt = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({m_req_o, s_r_valid_o, s_r_opc_o, timeout_o, s_gnt_o} !== 5'b0 ||
            s_r_rdata_o !== 32'h0 || err_count_o !== 8'h0 || m_add_o !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: m_req=%b rvalid=%b rdata=%h timeout=%b errcnt=%0d add=%h, required all 0",
                     m_req_o, s_r_valid_o, s_r_rdata_o, timeout_o, err_count_o, m_add_o);
        end
        #1 rst_n = 1'b1;
        s_req = 1'b1; s_add = 32'h4000_0010;
        #1;
        n_checks++;
        if (s_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL rst_new_gnt: got %b, required 1", s_gnt_o);
        end
        tick();
        s_req = 1'b0; m_gnt = 1'b1;
        tick();
        m_gnt = 1'b0; m_r_valid = 1'b1; m_r_rdata = 32'h0BAD_F00D;
        tick();
        m_r_valid = 1'b0;
        #1;
        n_checks++;
        if ({s_r_valid_o, s_r_opc_o, s_r_rdata_o} !== {1'b1, 1'b0, 32'h0BADF00D}) begin
            n_fail++;
            $display("FAIL rst_new_read: valid=%b opc=%b rdata=%h, required 1 0 0badf00d",
                     s_r_valid_o, s_r_opc_o, s_r_rdata_o);
        end
        tick();
        $display("txn read after async reset -> %h", s_r_rdata_o);
    endtask

    task automatic test_saturate_and_clr;
        bit ok;
        int lost;
        lost = 0;
        for (int n = 0; n < 300; n++) begin
            s_req = 1'b1; s_add = 32'h5000_0000;
            tick();
            s_req = 1'b0;
            ok = 1'b0;
            for (int k = 0; k < 40; k++) begin
                if (s_r_valid_o === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
                tick();
            end
            if (!ok) lost++;
        end
        n_checks++;
        if (lost !== 0) begin
            n_fail++; $display("FAIL sat_responses: %0d timeouts without error pulse, required 0", lost);
        end
        #1;
        n_checks++;
        if ({timeout_o, err_count_o} !== {1'b1, 8'd255}) begin
            n_fail++; $display("FAIL sat_count: timeout=%b errcnt=%0d, required 1 255", timeout_o, err_count_o);
        end
        tick();
        s_req = 1'b1;
        tick();
        s_req = 1'b0;
        repeat (16) tick();
        #1;
        n_checks++;
        if ({m_req_o, err_count_o} !== {1'b0, 8'd255}) begin
            n_fail++; $display("FAIL sat_err_state: m_req=%b errcnt=%0d, required 0 255", m_req_o, err_count_o);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        #1;
        n_checks++;
        if ({s_r_valid_o, timeout_o, err_count_o} !== {1'b1, 1'b1, 8'd1}) begin
            n_fail++;
            $display("FAIL clr_with_timeout: rvalid=%b timeout=%b errcnt=%0d, required 1 1 1",
                     s_r_valid_o, timeout_o, err_count_o);
        end
        tick();
        $display("txn 301 timeouts, clr coincident -> errcnt %0d", err_count_o);
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_delayed_grant();
        test_grant_timeout();
        test_resp_timeout_stale();
        test_stale_in_resp();
        test_back_to_back();
        test_async_reset();
        test_saturate_and_clr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
